regfile_sequencer: RTL
======================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter W, default 32, giving the data width of the register-file port, operands and result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, block can accept a command.
REQ-006 SHALL have port cmd_op, input, 3, operation code (see REQ-020).
REQ-007 SHALL have ports cmd_rd, cmd_rs1, cmd_rs2, input, 2 each, destination and source register indices.
REQ-008 SHALL have port cmd_imm, input, W, immediate operand for LOADI.
REQ-009 SHALL have port rf_WE, output, 1, register-file write enable.
REQ-010 SHALL have port rf_addr_input, output, 2, register-file write address.
REQ-011 SHALL have ports rf_addr_out1, rf_addr_out2, output, 2 each, register-file read addresses.
REQ-012 SHALL have port rf_data, output, W, register-file write data.
REQ-013 SHALL have ports rf_out1, rf_out2, input, W each, combinational register-file read data.
REQ-014 SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on command completion.
REQ-016 SHALL have ports result (output, W) and zero (output, 1), the last computed value and its result==0 flag.

Function
REQ-017 SHALL implement a state machine with states IDLE, READ, EXEC, WRITE, DONE.
REQ-018 SHALL assert cmd_ready only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready, latching op/rd/rs1/rs2/imm and moving to READ.
REQ-019 READ: SHALL drive rf_addr_out1=rs1 and rf_addr_out2=rs2 and capture rf_out1/rf_out2 into operand registers A/B at the end of the cycle; next state EXEC.
REQ-020 EXEC: SHALL compute result from A/B: 000 ADD A+B, 001 SUB A-B, 010 AND, 011 OR, 100 XOR, 101 LOADI = imm, 110 MOVE = A, 111 NOP (result unchanged); arithmetic is modulo 2^W, carries discarded.
REQ-021 EXEC: SHALL update zero = (new result == 0) for all ops except NOP; next state WRITE, or DONE for NOP.
REQ-022 WRITE: SHALL assert rf_WE=1 for exactly one cycle, with rf_addr_input=rd and rf_data=result; next state DONE.
REQ-023 DONE: SHALL assert done=1 for one cycle; next state IDLE.
REQ-024 rf_WE SHALL be 0 in every state except WRITE; rf_addr_* and rf_data outside their active states SHALL hold the latched command values (don't-care for the register file).
REQ-025 Latency: accept edge to done-high cycle SHALL be 4 cycles (READ, EXEC, WRITE, DONE), or 3 cycles for NOP; the next command can be accepted at the earliest in the cycle after done.
REQ-026 cmd_valid held while busy SHALL NOT be accepted and SHALL NOT alter latched fields; acceptance occurs once IDLE is reached.
REQ-027 A write in WRITE SHALL be visible to the READ of the following command (no forwarding needed; the register file updates at the WRITE edge).
REQ-028 rd equal to rs1 or rs2 SHALL behave as read-before-write within one command.

Reset
REQ-029 With reset high at an edge: state=IDLE, A=B=0, result=0, zero=1, done=0, rf_WE=0, busy=0, cmd_ready=1 from the following cycle.
REQ-030 Reset SHALL take priority over command acceptance and over every state transition; asserted in any state, including EXEC or WRITE, it aborts the command with no further rf_WE pulse and no done pulse.

Verification
REQ-031 After reset (register file all 0): LOADI r1 imm=5, then LOADI r2 imm=3 -> one rf_WE pulse each, addr 1 data 5 and addr 2 data 3; done 4 cycles after each accept.
REQ-032 Then ADD rd=3 rs1=1 rs2=2 -> rf_addr_out1=1, rf_addr_out2=2 in READ; WRITE addr 3 data 8; result=8, zero=0.
REQ-033 SUB rd=0 rs1=2 rs2=1 -> data 0xFFFFFFFE (W=32); XOR rd=1 rs1=1 rs2=1 -> data 0, zero=1.
REQ-034 NOP with cmd_valid held continuously for 10 cycles -> accepted only when cmd_ready, no rf_WE pulse, done 3 cycles after each accept, result/zero unchanged.
REQ-035 Back-to-back commands: MOVE rd=2 rs1=3 immediately followed by ADD rd=2 rs1=2 rs2=2 -> second READ sees 8, WRITE data 16.
REQ-036 Reset asserted during EXEC of an ADD -> no rf_WE pulse and no done; next cycle busy=0, cmd_ready=1, result=0.

Source files
------------

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer
// Description : Accepts one ALU command at a time. It reads two operands from
//               an external 4-entry register file, computes a result and
//               writes that result back to the register file. It then pulses
//               done.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_rd,
    input  logic [1:0]   cmd_rs1,
    input  logic [1:0]   cmd_rs2,
    input  logic [W-1:0] cmd_imm,
    output logic         rf_WE,
    output logic [1:0]   rf_addr_input,
    output logic [1:0]   rf_addr_out1,
    output logic [1:0]   rf_addr_out2,
    output logic [W-1:0] rf_data,
    input  logic [W-1:0] rf_out1,
    input  logic [W-1:0] rf_out2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         zero
);

    // Sequencer states
    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_READ  = 3'd1;
    localparam logic [2:0] C_EXEC  = 3'd2;
    localparam logic [2:0] C_WRITE = 3'd3;
    localparam logic [2:0] C_DONE  = 3'd4;

    // Operation codes
    localparam logic [2:0] C_OP_ADD   = 3'b000;
    localparam logic [2:0] C_OP_SUB   = 3'b001;
    localparam logic [2:0] C_OP_AND   = 3'b010;
    localparam logic [2:0] C_OP_OR    = 3'b011;
    localparam logic [2:0] C_OP_XOR   = 3'b100;
    localparam logic [2:0] C_OP_LOADI = 3'b101;
    localparam logic [2:0] C_OP_MOVE  = 3'b110;
    localparam logic [2:0] C_OP_NOP   = 3'b111;

    logic [2:0]   r_state;
    logic [2:0]   r_op;
    logic [1:0]   r_rd;
    logic [1:0]   r_rs1;
    logic [1:0]   r_rs2;
    logic [W-1:0] r_imm;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;
    logic         r_zero;
    logic [W-1:0] w_alu;

    // Result of the latched operation on the captured operands. NOP keeps the old result.
    always_comb begin
        w_alu = r_result;
        case (r_op)
            C_OP_ADD:   w_alu = r_a + r_b;
            C_OP_SUB:   w_alu = r_a - r_b;
            C_OP_AND:   w_alu = r_a & r_b;
            C_OP_OR:    w_alu = r_a | r_b;
            C_OP_XOR:   w_alu = r_a ^ r_b;
            C_OP_LOADI: w_alu = r_imm;
            C_OP_MOVE:  w_alu = r_a;
            default:    w_alu = r_result;
        endcase
    end

    // Sequencer state and datapath registers. Reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= C_IDLE;
            r_op     <= C_OP_NOP;
            r_rd     <= 2'd0;
            r_rs1    <= 2'd0;
            r_rs2    <= 2'd0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                C_IDLE: begin
                    // Command fields are only sampled here, so inputs that
                    // change while busy leave the command in flight untouched.
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_rd    <= cmd_rd;
                        r_rs1   <= cmd_rs1;
                        r_rs2   <= cmd_rs2;
                        r_imm   <= cmd_imm;
                        r_state <= C_READ;
                    end
                end
                C_READ: begin
                    r_a     <= rf_out1;
                    r_b     <= rf_out2;
                    r_state <= C_EXEC;
                end
                C_EXEC: begin
                    if (r_op == C_OP_NOP) begin
                        r_state <= C_DONE;
                    end else begin
                        r_result <= w_alu;
                        r_zero   <= (w_alu == '0);
                        r_state  <= C_WRITE;
                    end
                end
                C_WRITE: r_state <= C_DONE;
                C_DONE:  r_state <= C_IDLE;
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (r_state == C_IDLE);
    assign busy          = (r_state != C_IDLE);
    assign done          = (r_state == C_DONE);
    assign rf_WE         = (r_state == C_WRITE);
    // Addresses and data are driven from the latched command at all times.
    // The register file ignores them outside READ and WRITE.
    assign rf_addr_input = r_rd;
    assign rf_addr_out1  = r_rs1;
    assign rf_addr_out2  = r_rs2;
    assign rf_data       = r_result;
    assign result        = r_result;
    assign zero          = r_zero;

endmodule
`default_nettype wire
